// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Shares the CPU's single memory bus between the instruction fetch port (A) and
// the load/store port (B). One transaction is held on the downstream bus at a
// time. Ties are broken round-robin against the last granted port. Read data and
// the completion pulse are routed combinationally back to the granted port. A
// watchdog aborts a granted transaction that sees no i_bus_ready for TIMEOUT
// grant cycles and reports it with a one-cycle error pulse.
//
// Ports
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_a_* / i_b_*               requester inputs: request (held until done),
//                               rw (1 = write), address, write data
//   o_a_* / o_b_*               requester outputs: rdata (valid with ready),
//                               ready pulse, timeout error pulse
//   o_bus_request/rw/address/wdata   registered downstream request
//   i_bus_rdata, i_bus_ready         downstream response (ready is one cycle)
// -----------------------------------------------------------------------------
module cpu_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clock,
  input  logic          i_reset,

  input  logic          i_a_request,
  input  logic          i_a_rw,
  input  logic [AW-1:0] i_a_address,
  input  logic [DW-1:0] i_a_wdata,
  output logic [DW-1:0] o_a_rdata,
  output logic          o_a_ready,
  output logic          o_a_error,

  input  logic          i_b_request,
  input  logic          i_b_rw,
  input  logic [AW-1:0] i_b_address,
  input  logic [DW-1:0] i_b_wdata,
  output logic [DW-1:0] o_b_rdata,
  output logic          o_b_ready,
  output logic          o_b_error,

  output logic          o_bus_request,
  output logic          o_bus_rw,
  output logic [AW-1:0] o_bus_address,
  output logic [DW-1:0] o_bus_wdata,
  input  logic [DW-1:0] i_bus_rdata,
  input  logic          i_bus_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter value during the TIMEOUT-th grant cycle (counter is 0 in the first).
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          bus_rw_q, bus_rw_d;
  logic [AW-1:0] bus_address_q, bus_address_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic          wdog_expired;
  assign wdog_expired = (wdog_q == WDOG_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= IDLE;
      last_q        <= LAST_B;  // A wins the first tie after reset
      wdog_q        <= '0;
      bus_rw_q      <= 1'b0;
      bus_address_q <= '0;
      bus_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      bus_rw_q      <= bus_rw_d;
      bus_address_q <= bus_address_d;
      bus_wdata_q   <= bus_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    wdog_d        = wdog_q;
    bus_rw_d      = bus_rw_q;
    bus_address_d = bus_address_q;
    bus_wdata_d   = bus_wdata_q;

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        // A wins when alone, or on a tie when B had the previous grant.
        if (i_a_request && (!i_b_request || last_q == LAST_B)) begin
          state_d       = GRANT_A;
          bus_rw_d      = i_a_rw;
          bus_address_d = i_a_address;
          bus_wdata_d   = i_a_wdata;
        end else if (i_b_request) begin
          state_d       = GRANT_B;
          bus_rw_d      = i_b_rw;
          bus_address_d = i_b_address;
          bus_wdata_d   = i_b_wdata;
        end
      end

      GRANT_A, GRANT_B: begin
        // Completion takes precedence over a watchdog expiry in the same cycle.
        if (i_bus_ready || wdog_expired) begin
          state_d = IDLE;
          last_d  = (state_q == GRANT_B) ? LAST_B : LAST_A;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    logic complete;
    logic abort;

    // Reset suppresses any pulse in the cycle it is asserted, so an in-flight
    // transaction killed by reset never reports ready or error.
    complete = i_bus_ready & ~i_reset;
    abort    = ~i_bus_ready & wdog_expired & ~i_reset;

    o_bus_request = (state_q != IDLE);
    o_bus_rw      = bus_rw_q;
    o_bus_address = bus_address_q;
    o_bus_wdata   = bus_wdata_q;

    o_a_ready = (state_q == GRANT_A) & complete;
    o_a_error = (state_q == GRANT_A) & abort;
    o_a_rdata = o_a_ready ? i_bus_rdata : '0;

    o_b_ready = (state_q == GRANT_B) & complete;
    o_b_error = (state_q == GRANT_B) & abort;
    o_b_rdata = o_b_ready ? i_bus_rdata : '0;
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//
// Random requesters on both ports, a random bus responder and occasional
// resets. A transaction-level reference model (who owns the bus, how long it
// has waited, who was served last) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 4;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_ready, a_error, b_ready, b_error;
  logic          bus_request, bus_rw;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ready;

  // Requester state, index 0 = port A, 1 = port B.
  logic          req   [2];
  logic          rw    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  int            cool  [2];

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_a_request   (req[0]),
    .i_a_rw        (rw[0]),
    .i_a_address   (addr[0]),
    .i_a_wdata     (wdata[0]),
    .o_a_rdata     (a_rdata),
    .o_a_ready     (a_ready),
    .o_a_error     (a_error),
    .i_b_request   (req[1]),
    .i_b_rw        (rw[1]),
    .i_b_address   (addr[1]),
    .i_b_wdata     (wdata[1]),
    .o_b_rdata     (b_rdata),
    .o_b_ready     (b_ready),
    .o_b_error     (b_error),
    .o_bus_request (bus_request),
    .o_bus_rw      (bus_rw),
    .o_bus_address (bus_address),
    .o_bus_wdata   (bus_wdata),
    .i_bus_rdata   (bus_rdata),
    .i_bus_ready   (bus_ready)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int            m_owner;
  int            m_last;
  int            m_waited;   // grant cycles already spent without ready
  bit            m_fresh;    // no grant since reset: bus fields must read 0
  logic          m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  initial begin
    int e_rdy;
    int e_err;
    int n_done;

    m_owner = 0; m_last = 2; m_waited = 0; m_fresh = 1'b1;
    m_rw = 1'b0; m_addr = '0; m_wdata = '0;
    n_done = 0;

    rst       = 1'b1;
    bus_ready = 1'b0;
    bus_rdata = '0;
    // Both ports request straight out of reset: A must win the tie.
    for (int p = 0; p < 2; p++) begin
      req[p]   = 1'b1;
      rw[p]    = 1'($urandom_range(0, 1));
      addr[p]  = AW'($urandom);
      wdata[p] = DW'($urandom);
      cool[p]  = 0;
    end
    repeat (2) @(posedge clk);
    #1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      e_rdy = 0;
      e_err = 0;
      if (m_owner != 0 && !rst) begin
        if (bus_ready)              e_rdy = m_owner;
        else if (m_waited + 1 == TO) e_err = m_owner;
      end

      check_eq("bus_request", 64'(bus_request), 64'(m_owner != 0));
      check_eq("a_ready", 64'(a_ready), 64'(e_rdy == 1));
      check_eq("a_error", 64'(a_error), 64'(e_err == 1));
      check_eq("a_rdata", 64'(a_rdata), (e_rdy == 1) ? 64'(bus_rdata) : 64'(0));
      check_eq("b_ready", 64'(b_ready), 64'(e_rdy == 2));
      check_eq("b_error", 64'(b_error), 64'(e_err == 2));
      check_eq("b_rdata", 64'(b_rdata), (e_rdy == 2) ? 64'(bus_rdata) : 64'(0));
      if (m_owner != 0 || m_fresh) begin
        check_eq("bus_rw", 64'(bus_rw), 64'(m_rw));
        check_eq("bus_address", 64'(bus_address), 64'(m_addr));
        check_eq("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
      end

      if (e_rdy != 0 || e_err != 0) begin
        n_done++;
        $display("[TB] cycle %0d txn %0d port %s %s rw=%0d addr=%h wdata=%h rdata=%h",
                 cyc, n_done, (m_owner == 1) ? "A" : "B",
                 (e_rdy != 0) ? "ready" : "timeout", m_rw, m_addr, m_wdata,
                 (e_rdy != 0) ? bus_rdata : '0);
      end

      @(posedge clk);
      // Advance the model with the inputs of the cycle that just ended.
      if (rst) begin
        m_owner = 0; m_last = 2; m_waited = 0; m_fresh = 1'b1;
        m_rw = 1'b0; m_addr = '0; m_wdata = '0;
      end else if (m_owner == 0) begin
        if (req[0] && req[1]) m_owner = (m_last == 2) ? 1 : 2;
        else if (req[0])      m_owner = 1;
        else if (req[1])      m_owner = 2;
        if (m_owner != 0) begin
          m_rw     = rw[m_owner - 1];
          m_addr   = addr[m_owner - 1];
          m_wdata  = wdata[m_owner - 1];
          m_waited = 0;
          m_fresh  = 1'b0;
        end
      end else if (bus_ready || m_waited + 1 == TO) begin
        m_last  = m_owner;
        m_owner = 0;
        m_waited = 0;
      end else begin
        m_waited++;
      end

      #1;
      rst       = ($urandom_range(0, 199) == 0);
      bus_ready = ($urandom_range(0, 3) == 0);
      bus_rdata = DW'($urandom);
      for (int p = 0; p < 2; p++) begin
        if (e_rdy == p + 1 || e_err == p + 1) begin
          req[p]  = 1'b0;
          cool[p] = $urandom_range(0, 2);
        end else if (!req[p]) begin
          if (cool[p] > 0) cool[p]--;
          else if ($urandom_range(0, 3) != 0) begin
            req[p]   = 1'b1;
            rw[p]    = 1'($urandom_range(0, 1));
            addr[p]  = AW'($urandom);
            wdata[p] = DW'($urandom);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
